// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue, MTHI/MTLO and result bundle between controller and muldiv_unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  modport master (output start, op, srca, srcb, hi_we, lo_we, wd, input hi, lo, busy, done);
  modport slave (input start, op, srca, srcb, hi_we, lo_we, wd, output hi, lo, busy, done);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU with HI/LO registers
module muldiv_unit #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               div_q, sa_q, sb_q, dz_q, busy_q, done_q;
  logic [WIDTH-1:0]   m_q, a_raw_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [2*WIDTH:0]   sh;
  logic [WIDTH:0]     sum, rem;
  logic [WIDTH-1:0]   diff, abs_a, abs_b, quo, rmd, hi_res, lo_res;
  logic               sa, sb;
  assign sa    = bus.op[0] & bus.srca[WIDTH-1];
  assign sb    = bus.op[0] & bus.srcb[WIDTH-1];
  assign abs_a = sa ? -bus.srca : bus.srca;
  assign abs_b = sb ? -bus.srcb : bus.srcb;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  // One iteration of shift-add multiply or restoring divide, plus the sign-fixed final result
  always_comb begin
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    sh     = {acc_q, 1'b0};
    rem    = sh[2*WIDTH:WIDTH];
    diff   = rem[WIDTH-1:0] - m_q;
    acc_d  = !div_q ? {sum, acc_q[WIDTH-1:1]} :
             (rem >= {1'b0, m_q}) ? {diff, sh[WIDTH-1:1], 1'b1} : sh[2*WIDTH-1:0];
    prod   = (sa_q ^ sb_q) ? -acc_d : acc_d;
    quo    = (sa_q ^ sb_q) ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    rmd    = sa_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
    hi_res = !div_q ? prod[2*WIDTH-1:WIDTH] : dz_q ? a_raw_q : rmd;
    lo_res = !div_q ? prod[WIDTH-1:0] : dz_q ? '1 : quo;
  end
  // Control FSM: latch operands when idle, iterate WIDTH times, then commit HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      m_q     <= '0;
      a_raw_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.hi_we) hi_q <= bus.wd;
        if (bus.lo_we) lo_q <= bus.wd;
        if (bus.start) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          div_q   <= bus.op[1];
          sa_q    <= sa;
          sb_q    <= sb;
          dz_q    <= bus.srcb == '0;
          a_raw_q <= bus.srca;
          m_q     <= bus.op[1] ? abs_b : abs_a;
          acc_q   <= {{WIDTH{1'b0}}, bus.op[1] ? abs_a : abs_b};
        end
      end else begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          hi_q    <= hi_res;
          lo_q    <= lo_res;
        end
      end
    end
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide coprocessor with HI/LO result registers, attached downstream of the MIPS datapath (`proc.mips.dp`).
- Executes MULT, MULTU, DIV and DIVU issued by the controller. Computes one bit per clock and signals busy so the controller can stall MFHI/MFLO.
- Needed for the multiplication programme and for all later multi-cycle arithmetic programmes.

Parameters:
- WIDTH, 32, operand/register width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request a new operation; sampled on the rising edge.
- op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- srca  input  WIDTH  rs operand: multiplicand or dividend.
- srcb  input  WIDTH  rt operand: multiplier or divisor.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wd  input  WIDTH  MTHI/MTLO write data.
- hi  output  WIDTH  current HI register (MFHI source).
- lo  output  WIDTH  current LO register (MFLO source).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse after the result is written.

Behaviour:
- Reset state: hi=0, lo=0, busy=0, done=0, FSM in IDLE, iteration counter 0.
- FSM states:
  - IDLE: if start=1 at an edge, latch op and operands, go to RUN, busy=1.
  - RUN: one iteration per edge. After exactly WIDTH RUN edges, write hi/lo, go to IDLE, busy=0, done=1.
  - done is high only for the cycle following completion.
- Latency: start accepted at edge E0. busy is high from E0 to E(WIDTH). hi/lo show the new result after E(WIDTH). With WIDTH=32 this is 32 cycles.
- Signed operations: latch absolute values, run the unsigned core, then apply signs at completion.
  - MULT: product negated if the operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign (truncating division).
- MULTU/MULT: full 2*WIDTH-bit product; {hi,lo} = product.
- DIVU/DIV: restoring division; lo = quotient, hi = remainder.
- Divide by zero (any div op): lo = all ones, hi = srca as latched. No exception.
- DIV overflow (most-negative / -1): lo = 0x80000000, hi = 0.
- start while busy=1: ignored. Operands are not re-latched and the running operation is unaffected.
- hi_we/lo_we while busy=1: ignored.
- hi_we/lo_we while idle: write wd at the edge.
  - If start is also asserted at that edge, the write still occurs; the later result overwrites it.
- hi and lo are driven directly from registers. Intermediate iteration state is never visible on them.
- Reset asserted mid-operation: abort immediately. Return to the reset state; no partial result is written.
- The controller stalls on MFHI/MFLO whenever busy=1. The unit itself does not check reads.

Test Plan:
- Reset, then MULTU srca=7, srcb=6 → busy high for exactly 32 cycles; done pulses once; hi=00000000, lo=0000002A.
- MULTU FFFFFFFF×FFFFFFFF → hi=FFFFFFFE, lo=00000001.
- MULT FFFFFFFD×00000005 → hi=FFFFFFFF, lo=FFFFFFF1.
- DIVU 100/7 → lo=0000000E, hi=00000002.
- DIV FFFFFFF9/00000002 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU 5/0 → lo=FFFFFFFF, hi=00000005.
- DIV 80000000/FFFFFFFF → lo=80000000, hi=00000000.
- Start MULTU 3×3, then at cycle 10:
  - pulse start with MULTU 2×2 and hi_we with wd=12345678 → both ignored; final lo=00000009.
  - Alternative run: assert reset at cycle 10 instead → busy=0 and hi=lo=0 immediately, no done pulse.
  - After release, MTLO with wd=CAFEBABE → lo=CAFEBABE next cycle.
